// File: rtl/wb_slave_decoder_pkg.sv
// Shared types and default address maps for the Wishbone N-slave decoder.
package wb_slave_decoder_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StBusy = 2'd1,
      StResp = 2'd2,
      StErr  = 2'd3
   } dec_state_e;

   // SoC bus: IRAM, DRAM, peripherals and a spare window.
   localparam logic [127:0] SocBaseAddrs  = {32'h3000_3000, 32'h3000_2000,
                                             32'h3000_1000, 32'h3000_0000};
   localparam logic [31:0]  SocAddrWidths = {8'd12, 8'd12, 8'd12, 8'd12};

   // CPU-side peripheral bus: GPIO and timer.
   localparam logic [63:0]  PeriphBaseAddrs  = {32'h8000_0100, 32'h8000_0000};
   localparam logic [15:0]  PeriphAddrWidths = {8'd8, 8'd8};

   localparam int unsigned TimeoutCyclesDefault = 255;

   // Bits [31:width] take part in the compare; a width of 32 or more matches everything.
   function automatic logic [31:0] window_mask(input logic [7:0] width);
      return (width >= 8'd32) ? 32'h0 : (32'hFFFF_FFFF << width);
   endfunction

endpackage

// File: rtl/wb_addr_decode.sv
// Combinational address decoder: reports whether any slave window matches, and which one.
module wb_addr_decode
   import wb_slave_decoder_pkg::*;
#(
   parameter int unsigned              N_SLAVES          = 4,
   parameter logic [N_SLAVES*32-1:0]   SLAVE_BASE_ADDRS  = SocBaseAddrs,
   parameter logic [N_SLAVES*8-1:0]    SLAVE_ADDR_WIDTHS = SocAddrWidths
) (
   input  logic [31:0] adr,
   output logic        hit,
   output logic [2:0]  idx
);

   // Walk from the top index down so the lowest matching index is the one left standing.
   always_comb begin
      hit = 1'b0;
      idx = 3'd0;
      for (int i = int'(N_SLAVES) - 1; i >= 0; i--) begin
         if (((adr ^ SLAVE_BASE_ADDRS[32*i +: 32])
              & window_mask(SLAVE_ADDR_WIDTHS[8*i +: 8])) == 32'h0) begin
            hit = 1'b1;
            idx = 3'(i);
         end
      end
   end

endmodule

// File: rtl/wb_slave_decoder.sv
// Wishbone classic 1-to-N decoder with registered request/response and error on unmapped access.
// Optional bus watchdog is compiled in with WB_DEC_TIMEOUT_EN.
module wb_slave_decoder
   import wb_slave_decoder_pkg::*;
#(
   parameter int unsigned              N_SLAVES          = 4,
   parameter logic [N_SLAVES*32-1:0]   SLAVE_BASE_ADDRS  = SocBaseAddrs,
   parameter logic [N_SLAVES*8-1:0]    SLAVE_ADDR_WIDTHS = SocAddrWidths,
   parameter int unsigned              TIMEOUT_CYCLES    = TimeoutCyclesDefault
) (
   input  logic                    clk_i,
   input  logic                    rstn_i,
   input  logic                    wbs_cyc_i,
   input  logic                    wbs_stb_i,
   input  logic                    wbs_we_i,
   input  logic [3:0]              wbs_sel_i,
   input  logic [31:0]             wbs_adr_i,
   input  logic [31:0]             wbs_dat_i,
   output logic                    wbs_ack_o,
   output logic                    wbs_err_o,
   output logic [31:0]             wbs_dat_o,
   output logic [N_SLAVES-1:0]     wbm_cyc_o,
   output logic [N_SLAVES-1:0]     wbm_stb_o,
   output logic [N_SLAVES-1:0]     wbm_we_o,
   output logic [4*N_SLAVES-1:0]   wbm_sel_o,
   output logic [32*N_SLAVES-1:0]  wbm_adr_o,
   output logic [32*N_SLAVES-1:0]  wbm_dat_o,
   input  logic [N_SLAVES-1:0]     wbm_ack_i,
   input  logic [32*N_SLAVES-1:0]  wbm_dat_i,
   output logic                    timeout_o
);

   dec_state_e  state_q, state_d;
   logic [2:0]  idx_q, idx_d;
   logic        we_q, we_d;
   logic [3:0]  sel_q, sel_d;
   logic [31:0] adr_q, adr_d;
   logic [31:0] dat_q, dat_d;
   logic [31:0] rdata_q, rdata_d;

   logic        dec_hit;
   logic [2:0]  dec_idx;
   logic        sel_ack;
   logic [31:0] sel_rdata;
   logic        expired;

   wb_addr_decode #(
      .N_SLAVES          (N_SLAVES),
      .SLAVE_BASE_ADDRS  (SLAVE_BASE_ADDRS),
      .SLAVE_ADDR_WIDTHS (SLAVE_ADDR_WIDTHS)
   ) u_addr_decode (
      .adr (wbs_adr_i),
      .hit (dec_hit),
      .idx (dec_idx)
   );

   always_comb begin
      sel_ack   = 1'b0;
      sel_rdata = 32'h0;
      wbm_cyc_o = '0;
      for (int i = 0; i < int'(N_SLAVES); i++) begin
         if (idx_q == 3'(i)) begin
            sel_ack      = wbm_ack_i[i];
            sel_rdata    = wbm_dat_i[32*i +: 32];
            wbm_cyc_o[i] = (state_q == StBusy);
         end
      end
   end

   // Only cyc/stb are steered; everything else is broadcast from the request registers.
   assign wbm_stb_o = wbm_cyc_o;
   assign wbm_we_o  = {N_SLAVES{we_q}};
   assign wbm_sel_o = {N_SLAVES{sel_q}};
   assign wbm_adr_o = {N_SLAVES{adr_q}};
   assign wbm_dat_o = {N_SLAVES{dat_q}};

   assign wbs_ack_o = (state_q == StResp);
   assign wbs_err_o = (state_q == StErr);
   assign wbs_dat_o = rdata_q;

`ifdef WB_DEC_TIMEOUT_EN
   logic [15:0] cnt_q;
   logic        timeout_q;

   assign expired = (({1'b0, cnt_q} + 17'd1) == 17'(TIMEOUT_CYCLES));

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         cnt_q     <= 16'd0;
         timeout_q <= 1'b0;
      end else begin
         cnt_q     <= (state_q == StBusy) ? cnt_q + 16'd1 : 16'd0;
         // Abort and ack both take priority over expiry.
         timeout_q <= (state_q == StBusy) && wbs_cyc_i && !sel_ack && expired;
      end
   end

   assign timeout_o = timeout_q;
`else
   assign expired   = 1'b0;
   assign timeout_o = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      we_d    = we_q;
      sel_d   = sel_q;
      adr_d   = adr_q;
      dat_d   = dat_q;
      rdata_d = rdata_q;
      case (state_q)
         StIdle: begin
            if (wbs_cyc_i && wbs_stb_i) begin
               idx_d = dec_idx;
               we_d  = wbs_we_i;
               sel_d = wbs_sel_i;
               adr_d = wbs_adr_i;
               dat_d = wbs_dat_i;
               if (dec_hit) begin
                  state_d = StBusy;
               end else begin
                  state_d = StErr;
                  rdata_d = 32'h0;
               end
            end
         end
         StBusy: begin
            if (!wbs_cyc_i) begin
               state_d = StIdle;
            end else if (sel_ack) begin
               state_d = StResp;
               rdata_d = sel_rdata;
            end else if (expired) begin
               state_d = StErr;
               rdata_d = 32'h0;
            end
         end
         StResp:  state_d = StIdle;
         StErr:   state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
         state_q <= StIdle;
         idx_q   <= 3'd0;
         we_q    <= 1'b0;
         sel_q   <= 4'h0;
         adr_q   <= 32'h0;
         dat_q   <= 32'h0;
         rdata_q <= 32'h0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         we_q    <= we_d;
         sel_q   <= sel_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         rdata_q <= rdata_d;
      end
   end

endmodule

// File: tb/tb_wb_slave_decoder.sv
// Bench for wb_slave_decoder: directed and randomized transactions against an address-map model.
module tb_wb_slave_decoder;

   logic         clk_i = 1'b0;
   logic         rstn_i;
   logic         wbs_cyc_i, wbs_stb_i, wbs_we_i;
   logic [3:0]   wbs_sel_i;
   logic [31:0]  wbs_adr_i, wbs_dat_i;
   logic         wbs_ack_o, wbs_err_o;
   logic [31:0]  wbs_dat_o;
   logic [3:0]   wbm_cyc_o, wbm_stb_o, wbm_we_o;
   logic [15:0]  wbm_sel_o;
   logic [127:0] wbm_adr_o, wbm_dat_o;
   logic [3:0]   wbm_ack_i;
   logic [127:0] wbm_dat_i;
   logic         timeout_o;

   // Second decoder with overlapping windows, fed by the same master.
   logic [1:0]   ovl_cyc, ovl_stb, ovl_we;
   logic [7:0]   ovl_sel;
   logic [63:0]  ovl_adr, ovl_wdat;
   logic [1:0]   ovl_ack;
   logic [63:0]  ovl_rdat;
   logic         ovl_wbs_ack, ovl_wbs_err, ovl_timeout;
   logic [31:0]  ovl_wbs_dat;

   assign ovl_ack  = ovl_stb;
   assign ovl_rdat = 64'h0;

   int n_vec = 0;
   int n_mis = 0;

   // Transaction observations.
   int          r_ack_cyc, r_err_cyc, r_to_cyc;
   logic [31:0] r_dat, r_adr, r_wdat, r_post_dat;
   logic [3:0]  r_stb_or, r_stb_after_abort, r_sel, r_cyc_at_resp;
   logic        r_we, r_post_resp;
   logic [1:0]  r_ovl_stb1;

   logic [31:0] ref_base [4] = '{32'h3000_0000, 32'h3000_1000, 32'h3000_2000, 32'h3000_3000};
   int          ref_size [4] = '{4096, 4096, 4096, 4096};

   always #5 clk_i = ~clk_i;

   wb_slave_decoder #(
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk_i     (clk_i),
      .rstn_i    (rstn_i),
      .wbs_cyc_i (wbs_cyc_i),
      .wbs_stb_i (wbs_stb_i),
      .wbs_we_i  (wbs_we_i),
      .wbs_sel_i (wbs_sel_i),
      .wbs_adr_i (wbs_adr_i),
      .wbs_dat_i (wbs_dat_i),
      .wbs_ack_o (wbs_ack_o),
      .wbs_err_o (wbs_err_o),
      .wbs_dat_o (wbs_dat_o),
      .wbm_cyc_o (wbm_cyc_o),
      .wbm_stb_o (wbm_stb_o),
      .wbm_we_o  (wbm_we_o),
      .wbm_sel_o (wbm_sel_o),
      .wbm_adr_o (wbm_adr_o),
      .wbm_dat_o (wbm_dat_o),
      .wbm_ack_i (wbm_ack_i),
      .wbm_dat_i (wbm_dat_i),
      .timeout_o (timeout_o)
   );

   wb_slave_decoder #(
      .N_SLAVES          (2),
      .SLAVE_BASE_ADDRS  ({32'h3000_0000, 32'h3000_0000}),
      .SLAVE_ADDR_WIDTHS ({8'd13, 8'd12})
   ) dut_ovl (
      .clk_i     (clk_i),
      .rstn_i    (rstn_i),
      .wbs_cyc_i (wbs_cyc_i),
      .wbs_stb_i (wbs_stb_i),
      .wbs_we_i  (wbs_we_i),
      .wbs_sel_i (wbs_sel_i),
      .wbs_adr_i (wbs_adr_i),
      .wbs_dat_i (wbs_dat_i),
      .wbs_ack_o (ovl_wbs_ack),
      .wbs_err_o (ovl_wbs_err),
      .wbs_dat_o (ovl_wbs_dat),
      .wbm_cyc_o (ovl_cyc),
      .wbm_stb_o (ovl_stb),
      .wbm_we_o  (ovl_we),
      .wbm_sel_o (ovl_sel),
      .wbm_adr_o (ovl_adr),
      .wbm_dat_o (ovl_wdat),
      .wbm_ack_i (ovl_ack),
      .wbm_dat_i (ovl_rdat),
      .timeout_o (ovl_timeout)
   );

   // Reference decode: first window (lowest index) containing the address, else -1.
   function automatic int ref_decode(input logic [31:0] a);
      for (int i = 0; i < 4; i++) begin
         if (longint'(a) >= longint'(ref_base[i]) &&
             longint'(a) <  longint'(ref_base[i]) + longint'(ref_size[i]))
            return i;
      end
      return -1;
   endfunction

   // One master transaction; starts and ends at a negedge. Slaves ack on their
   // (waits+1)-th strobe cycle; idle slaves emit random stray acks.
   task automatic txn(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                      input logic [3:0] sel, input int waits, input logic [31:0] rdat,
                      input int abort_at, input int budget);
      int   strobes;
      logic done;
      strobes = 0;
      done = 1'b0;
      r_ack_cyc = -1; r_err_cyc = -1; r_to_cyc = -1;
      r_dat = 32'hx; r_adr = 32'hx; r_wdat = 32'hx; r_sel = 4'hx; r_we = 1'bx;
      r_stb_or = 4'h0; r_stb_after_abort = 4'h0; r_cyc_at_resp = 4'hx; r_ovl_stb1 = 2'h0;
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
      wbs_sel_i = sel; wbs_adr_i = adr; wbs_dat_i = wdat;
      for (int c = 1; c <= budget && !done; c++) begin
         @(posedge clk_i);
         @(negedge clk_i);
         if (c == 1) r_ovl_stb1 = ovl_stb;
         r_stb_or |= wbm_stb_o;
         if (abort_at >= 0 && c > abort_at) r_stb_after_abort |= wbm_stb_o;
         wbm_ack_i = 4'($urandom) & ~wbm_stb_o;
         wbm_dat_i = {$urandom, $urandom, $urandom, $urandom};
         if (wbm_stb_o != 4'h0) strobes++;
         for (int i = 0; i < 4; i++) begin
            if (wbm_stb_o[i]) begin
               r_adr  = wbm_adr_o[32*i +: 32];
               r_wdat = wbm_dat_o[32*i +: 32];
               r_sel  = wbm_sel_o[4*i +: 4];
               r_we   = wbm_we_o[i];
               if (strobes == waits + 1) begin
                  wbm_ack_i[i] = 1'b1;
                  wbm_dat_i[32*i +: 32] = rdat;
               end
            end
         end
         if (wbs_ack_o) begin
            r_ack_cyc = c; r_dat = wbs_dat_o; r_cyc_at_resp = wbm_cyc_o; done = 1'b1;
         end
         if (wbs_err_o) begin
            r_err_cyc = c; r_dat = wbs_dat_o; r_cyc_at_resp = wbm_cyc_o; done = 1'b1;
         end
         if (timeout_o) r_to_cyc = c;
         if (c == abort_at || done) begin
            wbs_cyc_i = 1'b0;
            wbs_stb_i = 1'b0;
         end
      end
      wbs_cyc_i = 1'b0;
      wbs_stb_i = 1'b0;
      wbm_ack_i = 4'h0;
      @(posedge clk_i);
      @(negedge clk_i);
      r_post_resp = wbs_ack_o | wbs_err_o | timeout_o;
      r_post_dat  = wbs_dat_o;
   endtask

   task automatic idle_cycles(input int n);
      wbs_cyc_i = 1'b0;
      wbs_stb_i = 1'b0;
      repeat (n) @(negedge clk_i);
   endtask

   task automatic test_reset();
      rstn_i = 1'b0;
      repeat (3) @(negedge clk_i);
      n_vec++;
      if ({wbs_ack_o, wbs_err_o, timeout_o} !== 3'b000) begin
         n_mis++;
         $display("FAIL reset_resp: got %b required 000", {wbs_ack_o, wbs_err_o, timeout_o});
      end
      n_vec++;
      if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o} !== 28'h0) begin
         n_mis++;
         $display("FAIL reset_ctrl: got %h required 0", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o});
      end
      n_vec++;
      if ({wbm_adr_o, wbm_dat_o, wbs_dat_o} !== 288'h0) begin
         n_mis++;
         $display("FAIL reset_data: got %h required 0", {wbm_adr_o, wbm_dat_o, wbs_dat_o});
      end
      rstn_i = 1'b1;
      @(negedge clk_i);
   endtask

   task automatic test_directed();
      txn(32'h3000_1004, 1'b1, 32'hDEAD_BEEF, 4'hF, 0, 32'h0BAD_F00D, -1, 20);
      n_vec++;
      if (r_ack_cyc !== 2) begin
         n_mis++; $display("FAIL wr_ack_cycle: got %0d required 2", r_ack_cyc);
      end
      n_vec++;
      if (r_stb_or !== 4'b0010) begin
         n_mis++; $display("FAIL wr_stb: got %b required 0010", r_stb_or);
      end
      n_vec++;
      if (r_wdat !== 32'hDEAD_BEEF || r_we !== 1'b1) begin
         n_mis++; $display("FAIL wr_data: got %h/%b required deadbeef/1", r_wdat, r_we);
      end

      txn(32'h3000_2010, 1'b0, 32'h0, 4'hF, 3, 32'h1234_5678, -1, 20);
      n_vec++;
      if (r_ack_cyc !== 5 || r_dat !== 32'h1234_5678) begin
         n_mis++;
         $display("FAIL rd_wait3: got cyc %0d dat %h required 5 12345678", r_ack_cyc, r_dat);
      end

      txn(32'h4000_0000, 1'b0, 32'h0, 4'hF, 0, 32'h5555_5555, -1, 20);
      n_vec++;
      if (r_err_cyc !== 1 || r_ack_cyc !== -1 || r_stb_or !== 4'h0 || r_dat !== 32'h0) begin
         n_mis++;
         $display("FAIL unmapped: got err %0d ack %0d stb %b dat %h required 1 -1 0000 0",
                  r_err_cyc, r_ack_cyc, r_stb_or, r_dat);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 40; n++) begin
         logic [31:0] adr, wdat, rdat;
         logic [3:0]  sel;
         logic        we;
         int          waits, pick, exp_idx;
         pick  = int'($urandom_range(0, 4));
         adr   = (pick < 4) ? ref_base[pick] + $urandom_range(0, 4095) : $urandom;
         we    = 1'($urandom);
         sel   = 4'($urandom);
         wdat  = $urandom;
         rdat  = $urandom;
         waits = int'($urandom_range(0, 4));
         exp_idx = ref_decode(adr);
         txn(adr, we, wdat, sel, waits, rdat, -1, 20);
         if (exp_idx >= 0) begin
            n_vec++;
            if (r_ack_cyc !== waits + 2 || r_err_cyc !== -1 || r_dat !== rdat) begin
               n_mis++;
               $display("FAIL rand_resp[%0d]: got ack %0d err %0d dat %h required %0d -1 %h",
                        n, r_ack_cyc, r_err_cyc, r_dat, waits + 2, rdat);
            end
            n_vec++;
            if (r_stb_or !== 4'(1 << exp_idx) || r_adr !== adr || r_wdat !== wdat ||
                r_we !== we || r_sel !== sel) begin
               n_mis++;
               $display("FAIL rand_req[%0d]: got stb %b adr %h dat %h we %b sel %h required %b %h %h %b %h",
                        n, r_stb_or, r_adr, r_wdat, r_we, r_sel, 4'(1 << exp_idx), adr, wdat, we, sel);
            end
            n_vec++;
            if (r_post_resp !== 1'b0 || r_post_dat !== rdat) begin
               n_mis++;
               $display("FAIL rand_hold[%0d]: got resp %b dat %h required 0 %h",
                        n, r_post_resp, r_post_dat, rdat);
            end
         end else begin
            n_vec++;
            if (r_err_cyc !== 1 || r_ack_cyc !== -1 || r_stb_or !== 4'h0 || r_dat !== 32'h0 ||
                r_post_resp !== 1'b0) begin
               n_mis++;
               $display("FAIL rand_unmapped[%0d]: got err %0d ack %0d stb %b dat %h post %b",
                        n, r_err_cyc, r_ack_cyc, r_stb_or, r_dat, r_post_resp);
            end
         end
         n_vec++;
         if (r_to_cyc !== -1) begin
            n_mis++; $display("FAIL rand_timeout[%0d]: got %0d required -1", n, r_to_cyc);
         end
      end
   endtask

   task automatic test_timeout();
      txn(32'h3000_3000, 1'b0, 32'h0, 4'hF, 1000, 32'h0, -1, 20);
`ifdef WB_DEC_TIMEOUT_EN
      n_vec++;
      if (r_err_cyc !== 9 || r_to_cyc !== 9 || r_ack_cyc !== -1 || r_cyc_at_resp[3] !== 1'b0) begin
         n_mis++;
         $display("FAIL watchdog: got err %0d to %0d ack %0d cyc3 %b required 9 9 -1 0",
                  r_err_cyc, r_to_cyc, r_ack_cyc, r_cyc_at_resp[3]);
      end
`else
      n_vec++;
      if (r_err_cyc !== -1 || r_to_cyc !== -1 || r_ack_cyc !== -1 || r_stb_or !== 4'b1000) begin
         n_mis++;
         $display("FAIL no_watchdog: got err %0d to %0d ack %0d stb %b required -1 -1 -1 1000",
                  r_err_cyc, r_to_cyc, r_ack_cyc, r_stb_or);
      end
`endif
      n_vec++;
      if (r_post_resp !== 1'b0) begin
         n_mis++; $display("FAIL stall_post: got %b required 0", r_post_resp);
      end
      // Ack lands on the expiry cycle.
      txn(32'h3000_3008, 1'b0, 32'h0, 4'hF, 7, 32'hA5A5_0F0F, -1, 20);
      n_vec++;
      if (r_ack_cyc !== 9 || r_err_cyc !== -1 || r_to_cyc !== -1 || r_dat !== 32'hA5A5_0F0F) begin
         n_mis++;
         $display("FAIL ack_at_expiry: got ack %0d err %0d to %0d dat %h required 9 -1 -1 a5a50f0f",
                  r_ack_cyc, r_err_cyc, r_to_cyc, r_dat);
      end
   endtask

   task automatic test_abort_reset();
      logic saw;
      // Stalling slave, then a slave ack coinciding with the cyc drop.
      for (int k = 0; k < 2; k++) begin
         txn(32'h3000_0010, 1'b0, 32'h0, 4'hF, (k == 0) ? 1000 : 1, 32'h7777_7777, 2, 6);
         n_vec++;
         if (r_ack_cyc !== -1 || r_err_cyc !== -1 || r_stb_after_abort !== 4'h0 ||
             r_post_resp !== 1'b0 || r_stb_or !== 4'b0001) begin
            n_mis++;
            $display("FAIL abort[%0d]: got ack %0d err %0d stb_after %b post %b stb %b",
                     k, r_ack_cyc, r_err_cyc, r_stb_after_abort, r_post_resp, r_stb_or);
         end
      end

      saw = 1'b0;
      wbm_ack_i = 4'h0;
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
      wbs_sel_i = 4'hF; wbs_adr_i = 32'h3000_0000; wbs_dat_i = 32'hC0FF_EE11;
      repeat (3) begin
         @(posedge clk_i);
         @(negedge clk_i);
         saw |= wbs_ack_o | wbs_err_o;
      end
      n_vec++;
      if (wbm_stb_o !== 4'b0001 || wbm_adr_o[31:0] !== 32'h3000_0000) begin
         n_mis++;
         $display("FAIL pre_reset_busy: got stb %b adr %h required 0001 30000000",
                  wbm_stb_o, wbm_adr_o[31:0]);
      end
      rstn_i = 1'b0;
      @(posedge clk_i);
      @(negedge clk_i);
      n_vec++;
      if ({wbs_ack_o, wbs_err_o, timeout_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o} !== 31'h0 ||
          {wbm_adr_o, wbm_dat_o, wbs_dat_o} !== 288'h0) begin
         n_mis++;
         $display("FAIL mid_reset: got ctrl %h adr %h dat %h rdat %h required all 0",
                  {wbs_ack_o, wbs_err_o, timeout_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o},
                  wbm_adr_o, wbm_dat_o, wbs_dat_o);
      end
      rstn_i = 1'b1;
      wbs_cyc_i = 1'b0;
      wbs_stb_i = 1'b0;
      repeat (2) begin
         @(posedge clk_i);
         @(negedge clk_i);
         saw |= wbs_ack_o | wbs_err_o;
      end
      n_vec++;
      if (saw !== 1'b0) begin
         n_mis++; $display("FAIL reset_no_resp: got %b required 0", saw);
      end
   endtask

   task automatic test_overlap();
      logic [31:0] adrs [3] = '{32'h3000_0000, 32'h3000_1800, 32'h3000_2000};
      logic [1:0]  exp  [3] = '{2'b01, 2'b10, 2'b00};
      for (int i = 0; i < 3; i++) begin
         idle_cycles(3);
         txn(adrs[i], 1'b0, 32'h0, 4'hF, 0, 32'h0, -1, 20);
         n_vec++;
         if (r_ovl_stb1 !== exp[i]) begin
            n_mis++;
            $display("FAIL overlap[%0d]: got %b required %b", i, r_ovl_stb1, exp[i]);
         end
      end
   endtask

   initial begin
      rstn_i    = 1'b0;
      wbs_cyc_i = 1'b0;
      wbs_stb_i = 1'b0;
      wbs_we_i  = 1'b0;
      wbs_sel_i = 4'h0;
      wbs_adr_i = 32'h0;
      wbs_dat_i = 32'h0;
      wbm_ack_i = 4'h0;
      wbm_dat_i = 128'h0;
      test_reset();
      test_directed();
      test_random();
      test_timeout();
      test_abort_reset();
      test_overlap();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
